// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin AR arbiter: one master holds the lock from grant until its RLAST beat is accepted; losers see ARREADY_M=0.
// Grant 1 cycle after request; defining AR_ARB_OUTREG_EN adds a registered AR slice (+1 cycle, flop-driven *_S outputs).
module axi_ar_rr_arbiter #(
  parameter int NUM_MST = 2,
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 4,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 32'h0003_0000,
  localparam int IDX_W = $clog2(NUM_MST)
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_MST*ID_W-1:0]   ARID_M,
  input  logic [NUM_MST*ADDR_W-1:0] ARADDR_M,
  input  logic [NUM_MST*LEN_W-1:0]  ARLEN_M,
  input  logic [NUM_MST*3-1:0]      ARSIZE_M,
  input  logic [NUM_MST*2-1:0]      ARBURST_M,
  input  logic [NUM_MST-1:0]        ARVALID_M,
  output logic [NUM_MST-1:0]        ARREADY_M,
  output logic [IDX_W+ID_W-1:0]     ARID_S,
  output logic [ADDR_W-1:0]         ARADDR_S,
  output logic [LEN_W-1:0]          ARLEN_S,
  output logic [2:0]                ARSIZE_S,
  output logic [1:0]                ARBURST_S,
  output logic                      ARVALID_S,
  input  logic                      ARREADY_S,
  input  logic                      RVALID_S,
  input  logic                      RLAST_S,
  input  logic [NUM_MST-1:0]        RREADY_M,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_vld
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx, grant_inc;
  logic             pick_vld, g_arvalid, last_hs;
  logic [ID_W-1:0]  g_id;
  logic [ADDR_W-1:0] g_addr;
  logic [LEN_W-1:0] g_len;
  logic [2:0]       g_size;
  logic [1:0]       g_burst;

  assign g_id      = ARID_M[int'(grant_q)*ID_W +: ID_W];
  assign g_addr    = ARADDR_M[int'(grant_q)*ADDR_W +: ADDR_W];
  assign g_len     = ARLEN_M[int'(grant_q)*LEN_W +: LEN_W];
  assign g_size    = ARSIZE_M[int'(grant_q)*3 +: 3];
  assign g_burst   = ARBURST_M[int'(grant_q)*2 +: 2];
  assign g_arvalid = ARVALID_M[grant_q];
  assign last_hs   = RVALID_S & RLAST_S & RREADY_M[grant_q];
  assign grant_inc = (int'(grant_q) == NUM_MST-1) ? '0 : grant_q + 1'b1;

  assign grant_idx = grant_q;
  assign grant_vld = (state_q != S_IDLE);

  // Scan from ptr downwards so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j = 0;
    for (int k = NUM_MST-1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_MST) j = j - NUM_MST;
      if (ARVALID_M[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef AR_ARB_OUTREG_EN
  logic                  sl_vld, mst_hs;
  logic [IDX_W+ID_W-1:0] sl_id;
  logic [ADDR_W-1:0]     sl_addr;
  logic [LEN_W-1:0]      sl_len;
  logic [2:0]            sl_size;
  logic [1:0]            sl_burst;

  assign mst_hs = (state_q == S_ADDR) & ~sl_vld & g_arvalid;

  // Slice returns to idle values once drained so the *_S bus reads as idle outside ADDR.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sl_vld   <= 1'b0;
      sl_id    <= '0;
      sl_addr  <= IDLE_ADDR;
      sl_len   <= '0;
      sl_size  <= '0;
      sl_burst <= '0;
    end else if (mst_hs) begin
      sl_vld   <= 1'b1;
      sl_id    <= {grant_q, g_id};
      sl_addr  <= g_addr;
      sl_len   <= g_len;
      sl_size  <= g_size;
      sl_burst <= g_burst;
    end else if (sl_vld & ARREADY_S) begin
      sl_vld   <= 1'b0;
      sl_id    <= '0;
      sl_addr  <= IDLE_ADDR;
      sl_len   <= '0;
      sl_size  <= '0;
      sl_burst <= '0;
    end
  end

  assign ARVALID_S = sl_vld;
  assign ARID_S    = sl_id;
  assign ARADDR_S  = sl_addr;
  assign ARLEN_S   = sl_len;
  assign ARSIZE_S  = sl_size;
  assign ARBURST_S = sl_burst;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    ARREADY_M = '0;
`ifndef AR_ARB_OUTREG_EN
    ARVALID_S = 1'b0;
    ARID_S    = '0;
    ARADDR_S  = IDLE_ADDR;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
`ifdef AR_ARB_OUTREG_EN
        ARREADY_M[grant_q] = ~sl_vld;
        if (mst_hs) ptr_d = grant_inc;
        if (sl_vld & ARREADY_S) state_d = S_DATA;
`else
        ARVALID_S          = g_arvalid;
        ARID_S             = {grant_q, g_id};
        ARADDR_S           = g_addr;
        ARLEN_S            = g_len;
        ARSIZE_S           = g_size;
        ARBURST_S          = g_burst;
        ARREADY_M[grant_q] = ARREADY_S;
        if (g_arvalid & ARREADY_S) begin
          state_d = S_DATA;
          ptr_d   = grant_inc;
        end
`endif
      end
      S_DATA: begin
        if (last_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
